vec_wb_packer: RTL and testbench
================================

# vec_wb_packer

Result write-back packer for the vector datapath. It consumes the stream of per-element 32-bit results produced by the processing element and packs 8/16/32-bit destination elements into 32-bit vector-register-file words. It writes each word to the VRF write port with byte enables, so one PE result is committed per cycle when the VRF does not stall. It sits between the PE output and the VRF write port, and is started once per vector instruction by the issue sequencer.

## Interface
- `VLEN`, 128: bits per vector register. `WPR = VLEN/32` words per register.
- `VL_W`, 8: width of the `vl` input.
- `REG_ADDR_W`, 5: vector register index width.
- `ADDR_W`, `REG_ADDR_W + $clog2(VLEN/32)`: linear VRF word-address width.

Ports:
- `clk`, in, 1: sole clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a sequence; samples `vd_addr`, `dest_sew` and `vl`. Ignored while `busy`.
- `vd_addr`, in, REG_ADDR_W: destination base register.
- `dest_sew`, in, 2: effective destination element width after widening. 0=8b, 1=16b, 2=32b; 3 is treated as 32b.
- `vl`, in, VL_W: number of elements to write.
- `res_valid`, in, 1: PE result valid.
- `res_data`, in, 32: PE result; the low 8/16/32 bits hold the element.
- `res_ready`, out, 1: packer accepts the element this cycle.
- `wr_en`, out, 1: VRF write request.
- `wr_ready`, in, 1: VRF accepts the write this cycle.
- `wr_addr`, out, ADDR_W: linear word address.
- `wr_data`, out, 32: packed word.
- `wr_be`, out, 4: byte enables.
- `busy`, out, 1: state is not IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- FSM states are `WB_IDLE`, `WB_COLLECT` and `WB_DRAIN`.
- **IDLE → COLLECT** on `start` with `vl != 0`. This clears the element counter, lane index, pack register and pack byte enables, and sets the word index to 0.
- **`start` with `vl == 0`**: `done` pulses the next cycle and the FSM stays in IDLE. No write is issued.
- **Accept condition**: an element is accepted on `res_valid && res_ready`.
- **Lane insertion**: the element's low `8<<dest_sew` bits are shifted into the lane selected by the lane index.
  - Lanes per word are 4, 2 or 1.
  - The covering byte enables are ORed into the pack byte enables.
  - Upper bits of `res_data` are discarded without saturation; saturation is upstream.
- **Word completion**: a word completes when the element fills the last lane or is element `vl-1`.
  - On completion the pack register, pack byte enables and current address are loaded into `wr_data`, `wr_be` and `wr_addr`, and `wr_en` is set.
  - The pack register and pack byte enables then clear, and the word index increments.
- **Partial final word**: unfilled bytes are zero with their byte enables at 0.
- **Address**: `wr_addr = (vd_addr*WPR + word_idx) mod 2^ADDR_W`. Addresses run past a register boundary into the following register (register groups), and wrap from the top address to 0.
- **Write handshake**: `wr_en`, `wr_addr`, `wr_data` and `wr_be` hold stable until `wr_en && wr_ready`. `wr_en` then clears, unless a new word loads on the same edge.
- **`res_ready`**: equals `state==WB_COLLECT && !(wr_en && !wr_ready)`, so accepts stall only while a write is stalled.
- **COLLECT → DRAIN** when element `vl-1` is accepted.
- **DRAIN → IDLE** on the final write handshake, with a `done` pulse the following cycle.
- **Reset**: takes precedence over everything, including mid-sequence. The FSM goes to IDLE, all outputs return to reset values, and any partial word is discarded.

## Timing
- **Reset values**: `res_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `wr_be` 0, `busy` 0, `done` 0.
- **Start**: `busy` and `res_ready` rise the cycle after `start`.
- **Write latency**: the element that completes a word is accepted at edge N; `wr_en` is high in cycle N+1.
- **Throughput**: with `wr_ready` held at 1, one element per cycle. There are no bubbles at word boundaries, and a new word can load on the same edge as the previous write's handshake.
- **Completion**: if the final write handshakes at edge M, `done` is high in cycle M+1 and `busy` is 0 from cycle M+1.

## Configuration
- **Macro**: `VEC_WB_PACKER_MASK_EN`.
- **Defined**:
  - Adds input `res_mask`, 1 bit, sampled with each accepted element.
  - `res_mask=0` consumes the element and advances the lane, but contributes no byte enables (mask-undisturbed).
  - A completed word whose byte enables are all 0 issues no write.
  - If that word is the final one, `done` pulses the cycle after the final element is accepted.
- **Undefined**: the port is absent and every element is enabled.

## Structure
- **Add to `accelerator_pkg`**:
  - `wb_state_t` enum (`WB_IDLE`, `WB_COLLECT`, `WB_DRAIN`).
  - `vsew_t`-style width encodings (`SEW_8`, `SEW_16`, `SEW_32`).
- **Sub-module `wb_lane_insert`**: combinational. Takes `dest_sew`, lane index and `res_data`; produces the shifted 32-bit data and 4-bit byte enables. The packer instantiates it once.

## Test plan
- **8b, `vl`=6, `vd`=3, VLEN=128**, elements with low bytes A1..A6, `wr_ready`=1:
  - Writes addr 12 with `0xA4A3A2A1`, `be` 0xF.
  - Writes addr 13 with `0x0000A6A5`, `be` 0x3.
  - `done` pulses one cycle later.
- **32b, `vl`=3, `wr_ready` low for 4 cycles on the first write**: `res_ready` is 0 during the stall and `wr_*` hold. Three writes occur to consecutive addresses with no lost or duplicated element.
- **`start` with `vl`=0**: `done` is high the next cycle; `wr_en` and `busy` stay 0.
- **16b, `vl`=10, `vd`=31**: five writes to addr 124, 125, 126, 127, 0, each with `be` 0xF.
- **`reset` after 2 of 4 8b elements accepted**: the next cycle has `busy` 0 and `wr_en` 0, with no write issued. A following `start` runs normally.
- **`VEC_WB_PACKER_MASK_EN` defined, 8b, `vl`=4, masks 1,0,1,0**: one write with `be` 0x5. A second run with masks 0,0,0,0 issues no write and still pulses `done`.

Source files
------------

// File: rtl/vec_wb_packer_pkg.sv
// ============================================================================
// Module      : vec_wb_packer_pkg
// Description : Shared types for the vector write-back packer: FSM state
//               encoding, destination element-width encoding and a helper
//               that folds the reserved width code onto 32b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_wb_packer_pkg;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_COLLECT = 2'd1,
      WB_DRAIN   = 2'd2
   } wb_state_t;

   typedef enum logic [1:0] {
      SEW_8  = 2'd0,
      SEW_16 = 2'd1,
      SEW_32 = 2'd2
   } vsew_t;

   // Encoding 3 is reserved and behaves as 32b.
   function automatic vsew_t sew_norm(input logic [1:0] sew);
      case (sew)
         2'd0:    return SEW_8;
         2'd1:    return SEW_16;
         default: return SEW_32;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/vec_wb_packer_lane_insert.sv
// ============================================================================
// Module      : wb_lane_insert
// Description : Combinational lane placement of one PE result into a 32-bit
//               VRF word. Keeps the low 8/16/32 bits of the result, shifts
//               them into the selected lane and produces covering byte enables.
// Ports       : dest_sew_i - element width code (3 treated as 32b)
//               lane_i     - lane index within the word
//               data_i     - raw PE result
//               data_o     - element shifted into its lane, other bits zero
//               be_o       - byte enables covering the lane
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_lane_insert
   import vec_wb_packer_pkg::*;
(
   input  logic [1:0]  dest_sew_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [3:0]  be_o
);

   always_comb begin
      data_o = '0;
      be_o   = '0;
      case (sew_norm(dest_sew_i))
         SEW_8: begin
            data_o = {24'h0, data_i[7:0]} << {lane_i, 3'b000};
            be_o   = 4'b0001 << lane_i;
         end
         SEW_16: begin
            data_o = {16'h0, data_i[15:0]} << {lane_i[0], 4'b0000};
            be_o   = 4'b0011 << {lane_i[0], 1'b0};
         end
         default: begin
            data_o = data_i;
            be_o   = 4'hF;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/vec_wb_packer.sv
// ============================================================================
// Module      : vec_wb_packer
// Description : Packs a stream of per-element PE results (8/16/32b elements)
//               into 32-bit VRF words and writes them with byte enables.
//               One element per cycle while the VRF does not stall.
// Ports       : clk, reset (sync, active-high)
//               start/vd_addr/dest_sew/vl - sequence launch from the sequencer
//               res_valid/res_data/res_ready - PE result stream
//               wr_en/wr_ready/wr_addr/wr_data/wr_be - VRF write port
//               busy, done - status (done is a one-cycle pulse)
//               res_mask - only with VEC_WB_PACKER_MASK_EN defined
// Config      : VEC_WB_PACKER_MASK_EN adds per-element mask input; masked
//               elements take a lane but contribute no byte enables, and an
//               all-masked word is not written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_wb_packer
   import vec_wb_packer_pkg::*;
#(
   parameter int VLEN       = 128,
   parameter int VL_W       = 8,
   parameter int REG_ADDR_W = 5,
   parameter int ADDR_W     = REG_ADDR_W + $clog2(VLEN/32)
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [REG_ADDR_W-1:0] vd_addr,
   input  logic [1:0]            dest_sew,
   input  logic [VL_W-1:0]       vl,
   input  logic                  res_valid,
   input  logic [31:0]           res_data,
`ifdef VEC_WB_PACKER_MASK_EN
   input  logic                  res_mask,
`endif
   output logic                  res_ready,
   output logic                  wr_en,
   input  logic                  wr_ready,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [31:0]           wr_data,
   output logic [3:0]            wr_be,
   output logic                  busy,
   output logic                  done
);

   localparam int              c_WPR_W  = $clog2(VLEN/32);
   localparam logic [VL_W-1:0] c_VL_ONE = VL_W'(1);

   wb_state_t           state_q, state_d;
   vsew_t               sew_q, sew_d;
   logic [VL_W-1:0]     vl_q, vl_d;
   logic [VL_W-1:0]     elem_cnt_q, elem_cnt_d;
   logic [1:0]          lane_q, lane_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
   logic [31:0]         pack_data_q, pack_data_d;
   logic [3:0]          pack_be_q, pack_be_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [3:0]          wr_be_q, wr_be_d;
   logic                done_q, done_d;

   logic [31:0] w_ins_data, w_elem_data, w_word_data;
   logic [3:0]  w_ins_be, w_elem_be, w_word_be;
   logic        w_elem_en, w_accept, w_wr_hs;
   logic        w_last_lane, w_last_elem, w_word_done, w_word_write;

   wb_lane_insert u_lane_insert (
      .dest_sew_i (sew_q),
      .lane_i     (lane_q),
      .data_i     (res_data),
      .data_o     (w_ins_data),
      .be_o       (w_ins_be)
   );

`ifdef VEC_WB_PACKER_MASK_EN
   assign w_elem_en = res_mask;
`else
   assign w_elem_en = 1'b1;
`endif

   assign w_elem_data = w_elem_en ? w_ins_data : 32'h0;
   assign w_elem_be   = w_elem_en ? w_ins_be   : 4'h0;
   assign w_word_data = pack_data_q | w_elem_data;
   assign w_word_be   = pack_be_q | w_elem_be;

   assign res_ready = (state_q == WB_COLLECT) && !(wr_en_q && !wr_ready);
   assign w_accept  = res_valid && res_ready;
   assign w_wr_hs   = wr_en_q && wr_ready;

   always_comb begin
      case (sew_q)
         SEW_8:   w_last_lane = (lane_q == 2'd3);
         SEW_16:  w_last_lane = (lane_q == 2'd1);
         default: w_last_lane = 1'b1;
      endcase
   end

   assign w_last_elem  = (elem_cnt_q == vl_q - c_VL_ONE);
   assign w_word_done  = w_last_lane || w_last_elem;
   // Without masking every element contributes enables, so this only
   // suppresses writes of fully masked words.
   assign w_word_write = (w_word_be != 4'h0);

   always_comb begin
      state_d     = state_q;
      sew_d       = sew_q;
      vl_d        = vl_q;
      elem_cnt_d  = elem_cnt_q;
      lane_d      = lane_q;
      base_d      = base_q;
      word_idx_d  = word_idx_q;
      pack_data_d = pack_data_q;
      pack_be_d   = pack_be_q;
      wr_en_d     = wr_en_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_be_d     = wr_be_q;
      done_d      = 1'b0;

      // A load below on the same edge overrides this clear.
      if (w_wr_hs) begin
         wr_en_d = 1'b0;
      end

      case (state_q)
         WB_IDLE: begin
            if (start) begin
               if (vl != '0) begin
                  state_d     = WB_COLLECT;
                  sew_d       = sew_norm(dest_sew);
                  vl_d        = vl;
                  base_d      = ADDR_W'(vd_addr) << c_WPR_W;
                  elem_cnt_d  = '0;
                  lane_d      = '0;
                  word_idx_d  = '0;
                  pack_data_d = '0;
                  pack_be_d   = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         WB_COLLECT: begin
            if (w_accept) begin
               elem_cnt_d = elem_cnt_q + c_VL_ONE;
               if (w_word_done) begin
                  pack_data_d = '0;
                  pack_be_d   = '0;
                  lane_d      = '0;
                  word_idx_d  = word_idx_q + ADDR_W'(1);
                  if (w_word_write) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = base_q + word_idx_q;
                     wr_data_d = w_word_data;
                     wr_be_d   = w_word_be;
                  end
               end else begin
                  pack_data_d = w_word_data;
                  pack_be_d   = w_word_be;
                  lane_d      = lane_q + 2'd1;
               end
               if (w_last_elem) begin
                  if (w_word_write) begin
                     state_d = WB_DRAIN;
                  end else begin
                     // Nothing left to write: finish right away.
                     state_d = WB_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         WB_DRAIN: begin
            if (w_wr_hs) begin
               state_d = WB_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WB_IDLE;
         sew_q       <= SEW_8;
         vl_q        <= '0;
         elem_cnt_q  <= '0;
         lane_q      <= '0;
         base_q      <= '0;
         word_idx_q  <= '0;
         pack_data_q <= '0;
         pack_be_q   <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_be_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sew_q       <= sew_d;
         vl_q        <= vl_d;
         elem_cnt_q  <= elem_cnt_d;
         lane_q      <= lane_d;
         base_q      <= base_d;
         word_idx_q  <= word_idx_d;
         pack_data_q <= pack_data_d;
         pack_be_q   <= pack_be_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_be_q     <= wr_be_d;
         done_q      <= done_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_be   = wr_be_q;
   assign busy    = (state_q != WB_IDLE);
   assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_wb_packer.sv
// ============================================================================
// Module      : tb_vec_wb_packer
// Description : Self-checking bench for vec_wb_packer: directed vector table,
//               hand-written reset / zero-length / mask sequences and random
//               runs compared against a word-level packing model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_wb_packer;

   logic        clk = 1'b0;
   logic        reset, start, res_valid, wr_ready;
   logic [4:0]  vd_addr;
   logic [1:0]  dest_sew;
   logic [7:0]  vl;
   logic [31:0] res_data;
   logic        res_ready, wr_en, busy, done;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
`ifdef VEC_WB_PACKER_MASK_EN
   logic        res_mask;
`endif

   always #5 clk = ~clk;

   vec_wb_packer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .vd_addr   (vd_addr),
      .dest_sew  (dest_sew),
      .vl        (vl),
      .res_valid (res_valid),
      .res_data  (res_data),
`ifdef VEC_WB_PACKER_MASK_EN
      .res_mask  (res_mask),
`endif
      .res_ready (res_ready),
      .wr_en     (wr_en),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_be     (wr_be),
      .busy      (busy),
      .done      (done)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] elems[$];
   bit          masks[$];
   logic [6:0]  got_addr[$], exp_addr[$];
   logic [31:0] got_data[$], exp_data[$];
   logic [3:0]  got_be[$],   exp_be[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Word-level model: element i lands in word i/epw, lane i%epw.
   function automatic void build_model(input int sew, input int nvl, input int vd);
      int bytes, epw, nw, idx;
      logic [63:0] emask;
      logic [31:0] d;
      logic [3:0]  b;
      bytes = (sew >= 2) ? 4 : (1 << sew);
      epw   = 4 / bytes;
      nw    = (nvl + epw - 1) / epw;
      emask = (64'd1 << (8 * bytes)) - 64'd1;
      exp_addr.delete(); exp_data.delete(); exp_be.delete();
      for (int w = 0; w < nw; w++) begin
         d = '0;
         b = '0;
         for (int j = 0; j < epw; j++) begin
            idx = w * epw + j;
            if (idx < nvl && masks[idx]) begin
               d = d | 32'(({32'h0, elems[idx]} & emask) << (8 * bytes * j));
               b = b | 4'(((1 << bytes) - 1) << (bytes * j));
            end
         end
         if (b != 4'h0) begin
            exp_addr.push_back(7'((vd * 4 + w) % 128));
            exp_data.push_back(d);
            exp_be.push_back(b);
         end
      end
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'h5A00_0000 | (32'(i + 1) << 16) | ((32'(8'hB0 + i) & 32'hFF) << 8)
             | (32'(8'hA1 + i) & 32'hFF);
   endfunction

   task automatic run_seq(input int t_sew, input int t_vl, input int t_vd,
                          input int t_stall, input bit t_rnd, input string tag);
      int idx = 0, n = 0, done_n = -1, last_wr_n = -1, last_acc_n = -1;
      int stall_left, exp_done;
      bit prev_stall = 0, all_en = 1, busy_at_done = 1;
      logic [6:0]  pa = '0;
      logic [31:0] pd = '0;
      logic [3:0]  pb = '0;
      stall_left = t_stall;
      got_addr.delete(); got_data.delete(); got_be.delete();
      build_model(t_sew, t_vl, t_vd);
      for (int i = 0; i < t_vl; i++) if (!masks[i]) all_en = 0;

      @(posedge clk); #1;
      start = 1; dest_sew = t_sew[1:0]; vl = t_vl[7:0]; vd_addr = t_vd[4:0];
      res_valid = 0; wr_ready = 1;
      @(posedge clk); #1;
      start = 0;
      while (done_n < 0 && n < 1000) begin
         res_valid = (idx < t_vl) && (t_rnd ? ($urandom % 4 != 0) : 1'b1);
         res_data  = (idx < t_vl) ? elems[idx] : $urandom;
`ifdef VEC_WB_PACKER_MASK_EN
         res_mask  = (idx < t_vl) ? masks[idx] : 1'b0;
`endif
         if (wr_en && stall_left > 0) begin
            wr_ready = 0;
            stall_left--;
         end else begin
            wr_ready = t_rnd ? ($urandom % 3 != 0) : 1'b1;
         end
         @(negedge clk);
         if (prev_stall) begin
            chk({tag, ":hold_en"},   wr_en,   1);
            chk({tag, ":hold_addr"}, wr_addr, pa);
            chk({tag, ":hold_data"}, wr_data, pd);
            chk({tag, ":hold_be"},   wr_be,   pb);
         end
         if (wr_en && !wr_ready) chk({tag, ":ready_stall"}, res_ready, 0);
         if (t_vl == 0) begin
            chk({tag, ":busy_vl0"}, busy, 0);
            chk({tag, ":wren_vl0"}, wr_en, 0);
         end else if (n == 0) begin
            chk({tag, ":busy_start"},  busy, 1);
            chk({tag, ":ready_start"}, res_ready, 1);
         end
         if (res_valid && res_ready) begin
            idx++;
            last_acc_n = n;
         end
         if (wr_en && wr_ready) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_be.push_back(wr_be);
            last_wr_n = n;
         end
         prev_stall = wr_en && !wr_ready;
         pa = wr_addr; pd = wr_data; pb = wr_be;
         if (done) begin
            done_n = n;
            busy_at_done = busy;
         end
         n++;
         @(posedge clk); #1;
      end
      res_valid = 0;
      wr_ready  = 1;
      if (done_n < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s:timeout no done after %0d cycles", tag, n);
      end else begin
         chk({tag, ":busy_at_done"}, busy_at_done, 0);
         if (exp_addr.size() > 0)  exp_done = last_wr_n + 1;
         else if (t_vl == 0)       exp_done = 0;
         else                      exp_done = last_acc_n + 1;
         chk({tag, ":done_cycle"}, done_n, exp_done);
         if (!t_rnd && t_stall == 0 && all_en && t_vl > 0)
            chk({tag, ":throughput"}, done_n, t_vl + 1);
      end
      chk({tag, ":accepted"}, idx, t_vl);
      chk({tag, ":n_writes"}, got_addr.size(), exp_addr.size());
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
         chk({tag, ":addr"}, got_addr[i], exp_addr[i]);
         chk({tag, ":data"}, got_data[i], exp_data[i]);
         chk({tag, ":be"},   got_be[i],   exp_be[i]);
      end
      @(negedge clk);
      chk({tag, ":done_pulse"}, done, 0);
   endtask

   typedef struct {
      int          sew, nvl, vd, stall;
      bit          rnd;
      int          nwr;
      logic [6:0]  a0, al;
      logic [31:0] d0, dl;
      logic [3:0]  bl;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{0,  6,  3, 0, 0, 2, 7'd12,  7'd13, 32'hA4A3A2A1, 32'h0000A6A5, 4'h3};
      tbl[1] = '{2,  3,  5, 4, 0, 3, 7'd20,  7'd22, 32'h5A01B0A1, 32'h5A03B2A3, 4'hF};
      tbl[2] = '{1, 10, 31, 0, 0, 5, 7'd124, 7'd0,  32'hB1A2B0A1, 32'hB9AAB8A9, 4'hF};
      tbl[3] = '{1,  3,  0, 0, 0, 2, 7'd0,   7'd1,  32'hB1A2B0A1, 32'h0000B2A3, 4'h3};
      tbl[4] = '{0,  1,  2, 0, 1, 1, 7'd8,   7'd8,  32'h000000A1, 32'h000000A1, 4'h1};
      tbl[5] = '{3,  2,  1, 0, 1, 2, 7'd4,   7'd5,  32'h5A01B0A1, 32'h5A02B1A2, 4'hF};

      reset = 1; start = 0; vd_addr = 0; dest_sew = 0; vl = 0;
      res_valid = 0; res_data = 0; wr_ready = 1;
`ifdef VEC_WB_PACKER_MASK_EN
      res_mask = 1;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst:res_ready", res_ready, 0);
      chk("rst:wr_en",     wr_en,     0);
      chk("rst:wr_addr",   wr_addr,   0);
      chk("rst:wr_data",   wr_data,   0);
      chk("rst:wr_be",     wr_be,     0);
      chk("rst:busy",      busy,      0);
      chk("rst:done",      done,      0);
      @(posedge clk); #1;
      reset = 0;

      // Directed table
      foreach (tbl[k]) begin
         elems.delete(); masks.delete();
         for (int i = 0; i < tbl[k].nvl; i++) begin
            elems.push_back(pat(i));
            masks.push_back(1'b1);
         end
         run_seq(tbl[k].sew, tbl[k].nvl, tbl[k].vd, tbl[k].stall, tbl[k].rnd,
                 $sformatf("tbl%0d", k));
         chk($sformatf("tbl%0d:nwr", k), got_addr.size(), tbl[k].nwr);
         if (got_addr.size() > 0) begin
            chk($sformatf("tbl%0d:a0", k), got_addr[0], tbl[k].a0);
            chk($sformatf("tbl%0d:d0", k), got_data[0], tbl[k].d0);
            chk($sformatf("tbl%0d:al", k), got_addr[got_addr.size()-1], tbl[k].al);
            chk($sformatf("tbl%0d:dl", k), got_data[got_data.size()-1], tbl[k].dl);
            chk($sformatf("tbl%0d:bl", k), got_be[got_be.size()-1], tbl[k].bl);
         end
      end

      // Zero-length start
      elems.delete(); masks.delete();
      run_seq(0, 0, 7, 0, 0, "vl0");

      // Reset after two of four 8b elements
      @(posedge clk); #1;
      start = 1; dest_sew = 0; vl = 4; vd_addr = 1;
      @(posedge clk); #1;
      start = 0; res_valid = 1; res_data = 32'h11;
`ifdef VEC_WB_PACKER_MASK_EN
      res_mask = 1;
`endif
      @(negedge clk);
      chk("rstmid:ready0", res_ready, 1);
      @(posedge clk); #1;
      res_data = 32'h22;
      @(negedge clk);
      chk("rstmid:ready1", res_ready, 1);
      @(posedge clk); #1;
      res_valid = 0; reset = 1;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("rstmid:busy",      busy,      0);
      chk("rstmid:wr_en",     wr_en,     0);
      chk("rstmid:res_ready", res_ready, 0);
      chk("rstmid:done",      done,      0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstmid:no_write", wr_en, 0);
      end
      elems.delete(); masks.delete();
      for (int i = 0; i < 4; i++) begin
         elems.push_back(pat(i));
         masks.push_back(1'b1);
      end
      run_seq(0, 4, 1, 0, 0, "after_rst");

`ifdef VEC_WB_PACKER_MASK_EN
      elems.delete(); masks.delete();
      for (int i = 0; i < 4; i++) begin
         elems.push_back(pat(i));
         masks.push_back(i % 2 == 0);
      end
      run_seq(0, 4, 2, 0, 0, "mask1010");
      chk("mask1010:nwr", got_addr.size(), 1);
      if (got_be.size() > 0) chk("mask1010:be", got_be[0], 4'h5);
      for (int i = 0; i < 4; i++) masks[i] = 1'b0;
      run_seq(0, 4, 2, 0, 0, "mask0000");
      chk("mask0000:nwr", got_addr.size(), 0);
`endif

      // Random runs against the model
      for (int r = 0; r < 25; r++) begin
         int rs, rv, rd, rst;
         rs  = $urandom % 4;
         rv  = $urandom_range(1, 40);
         rd  = $urandom % 32;
         rst = $urandom % 3;
         elems.delete(); masks.delete();
         for (int i = 0; i < rv; i++) begin
            elems.push_back($urandom);
`ifdef VEC_WB_PACKER_MASK_EN
            masks.push_back($urandom % 2 == 1);
`else
            masks.push_back(1'b1);
`endif
         end
         run_seq(rs, rv, rd, rst, 1'b1, $sformatf("rnd%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
